// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, host and data-memory signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_we;
  logic [DATA_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              last_grant;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata,
    output busy, last_grant
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata,
    input  busy, last_grant
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/host arbiter for the single-port data memory; DMEM_ARB_CPU_PRIO_EN gives the CPU strict priority
module dmem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_q, grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              pick_host;
  logic              any_req;
  logic              cpu_ack_w;
  logic              host_ack_w;

  assign any_req = bus.cpu_req | bus.host_req;

`ifdef DMEM_ARB_CPU_PRIO_EN
  // Strict priority: the host is granted only when the CPU is not asking.
  assign pick_host = bus.host_req & ~bus.cpu_req;
`else
  // Round-robin: on contention the port that did not own the last grant wins.
  assign pick_host = bus.host_req & (~bus.cpu_req | ~grant_q);
`endif

  // Next-state logic, request latching and read-data capture into the winner's register.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick_host;
          we_d    = pick_host ? bus.host_we    : bus.cpu_we;
          addr_d  = pick_host ? bus.host_addr  : bus.cpu_addr;
          wdata_d = pick_host ? bus.host_wdata : bus.cpu_wdata;
          cnt_d   = LAT_M1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = (we_q || (MEM_LAT <= 1)) ? DONE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Read data is sampled on the edge that enters DONE; the other port's register holds.
    if (!we_q && ((state_q == ACCESS) || (state_q == WAIT)) && (state_d == DONE)) begin
      if (grant_q) begin
        host_rdata_d = bus.mem_rdata;
      end else begin
        cpu_rdata_d = bus.mem_rdata;
      end
    end
  end

  // State register; reset abandons any in-flight access and hands the first contention to the CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      grant_q      <= 1'b1;
      cnt_q        <= 4'd0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign cpu_ack_w  = (state_q == DONE) & ~grant_q;
  assign host_ack_w = (state_q == DONE) & grant_q;

  assign bus.cpu_ack    = cpu_ack_w;
  assign bus.host_ack   = host_ack_w;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_ack_w;

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = (state_q == ACCESS) & we_q;
  assign bus.mem_re     = (state_q == ACCESS) & ~we_q;

  assign bus.busy       = (state_q != IDLE);
  assign bus.last_grant = grant_q;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the pipeline MEM stage (CPU port) and a host/loader port used to preload and read back data memory. It sequences each access through a small FSM, drives the memory's address, write-data and enable lines, and returns read data with a one-cycle acknowledge. It also produces a stall for the pipeline while the CPU port is waiting. It sits between the MEM-stage registers and the data memory, alongside the existing hazard/stall logic.

## Interface
Parameters:
- `DATA_W`, 32: data and address width.
- `MEM_LAT`, 1: cycles from the memory access cycle to `mem_rdata` valid; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  DATA_W  word address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  read data; valid while `cpu_ack`=1, held until the next CPU read completes.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`; combinational; feeds PC/IF-ID write-enable logic.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_ack`, `host_rdata`: same directions, widths and meanings as the CPU set, for the host.
- `mem_addr`  out  DATA_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_re`  out  1  memory read enable.
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  FSM not in IDLE.
- `last_grant`  out  1  0 = CPU, 1 = host; owner of the most recent grant.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any request is high, pick a winner. Latch its `we`, `addr` and `wdata`, set `last_grant`, and go to ACCESS. Otherwise stay in IDLE.
- Winner selection: only one request high → that requester wins. Both high → the requester that is not `last_grant` wins (round-robin).
- ACCESS (one cycle):
  - `mem_addr` and `mem_wdata` driven from the latched values.
  - `mem_we` = latched `we`; `mem_re` = not latched `we`.
  - Next state: a write goes to DONE. A read goes to WAIT if `MEM_LAT` > 1, otherwise to DONE.
- WAIT: a 4-bit down-counter, loaded with `MEM_LAT`-1 on entry to ACCESS, decrements each cycle. Go to DONE when it reaches 0.
- `mem_rdata` is captured into the winner's rdata register at the edge that enters DONE, for reads only.
- DONE (one cycle): assert the winner's `ack`, then return to IDLE unconditionally.
- Outside ACCESS, `mem_we` = `mem_re` = 0. `mem_addr`/`mem_wdata` keep the latched values.
- Only the granted requester's `ack`/`rdata` change. The other port's outputs hold.
- A request dropped mid-transaction is ignored: the access completes and `ack` still pulses.
- A request still high in the cycle after `ack` is treated as a new request.

## Timing
- Request sampled high in IDLE at edge k.
  - ACCESS is cycle k+1.
  - Write: `ack` in cycle k+2.
  - Read: `ack` in cycle k+1+`MEM_LAT`; `mem_rdata` must be valid in cycle k+`MEM_LAT`.
- DONE → IDLE always adds one idle cycle. Sustained throughput is one write per 3 cycles, or one read per `MEM_LAT`+2 cycles.
- Reset values: FSM = IDLE; `last_grant` = 1, so the CPU wins the first contention. All other outputs and registers are 0. `busy` = 0 and `cpu_stall` = `cpu_req`.
- Reset asserted mid-transaction: the in-flight access is abandoned, `mem_we` drops asynchronously, and no `ack` is issued. After reset releases, a still-held request restarts from IDLE.
- Both requests arriving in the same cycle are handled by the round-robin rule. A loser keeps its request high and wins the next IDLE cycle.

## Configuration
- `DMEM_ARB_CPU_PRIO_EN`:
  - Defined: CPU has strict priority. When both requests are high, the CPU always wins. The host is served only in IDLE cycles with `cpu_req`=0. `last_grant` is still updated.
  - Undefined: round-robin as described under Operation.

## Test plan
- Reset, then CPU write with `addr`=0x10 and `wdata`=0xDEADBEEF, at `MEM_LAT`=1:
  - `mem_we`=1 for exactly one cycle, with `mem_addr`=0x10.
  - `cpu_ack` fires 2 cycles after the request edge.
  - `cpu_stall` is high for 2 cycles.
- CPU read of 0x10 with `MEM_LAT`=3 and a memory model returning 0xDEADBEEF: `cpu_ack` in cycle k+4, `cpu_rdata`=0xDEADBEEF, and the value holds after `ack`.
- CPU and host both requesting continuously (reads), round-robin build:
  - Grants alternate CPU, host, CPU, host.
  - Each port gets one `ack` per two transactions.
  - The first grant after reset goes to the CPU.
- Same stimulus with `DMEM_ARB_CPU_PRIO_EN` defined: only `cpu_ack` pulses. Drop `cpu_req` and `host_ack` follows within 4 cycles.
- Assert `reset` during WAIT of a host read: the FSM returns to IDLE, there is no `host_ack`, `mem_re`=0, and `busy`=0. After release, the held `host_req` completes normally.
- Host writes 0x55 to 0x20 and the CPU then reads 0x20: `cpu_rdata`=0x55, and `host_rdata` is unchanged by the CPU read.
